cache_mem_bridge: RTL and testbench
===================================

Name: cache_mem_bridge

Overview:
- Downstream stage of the cache data array: consumes its miss requests (mem_read_req / mem_write_req) and the writeback line, and runs the main-memory transaction sequence.
- Dirty miss: writeback of the victim word, then refill of the requested word. Clean miss: refill only.
- Returns a one-cycle Main_mem_ack with the refill word on mem_data_out.
- Memory side is a single-outstanding valid/ready request channel plus a response-valid channel.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data word width.
- TIMEOUT, 255, maximum cycles to wait for m_rvalid in a response state before aborting.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_read_req  in  1  clean-miss refill request from the cache.
- mem_write_req  in  1  dirty-miss request: writeback, then refill.
- req_addr  in  ADDR_W  address of the missing word.
- wb_addr  in  ADDR_W  address of the dirty victim word.
- wb_data  in  DATA_W  dirty victim data.
- Main_mem_ack  out  1  one-cycle pulse; mem_data_out valid in the same cycle.
- mem_data_out  out  DATA_W  refill data to the cache.
- busy  out  1  high whenever the state is not IDLE.
- mem_err  out  1  sticky timeout flag, cleared only by reset.
- m_valid  out  1  memory request valid.
- m_ready  in  1  memory accepts the request.
- m_we  out  1  1 = write, 0 = read.
- m_addr  out  ADDR_W  word-aligned address: addr[ADDR_W-1:2], 2'b00.
- m_wdata  out  DATA_W  write data.
- m_rvalid  in  1  memory response valid (read data, or write completion).
- m_rdata  in  DATA_W  read response data.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE; Main_mem_ack=0; mem_data_out=0; busy=0; mem_err=0; m_valid=0; m_we=0; m_addr=0; m_wdata=0; timeout counter=0.
- Reset asserted mid-transaction: the next edge forces IDLE and drops m_valid. Any in-flight memory response is ignored.
- FSM states: IDLE, WB_REQ, WB_RESP, RD_REQ, RD_RESP, ACK.
- IDLE:
  - mem_write_req=1 -> capture req_addr, wb_addr, wb_data; go to WB_REQ.
  - Otherwise, mem_read_req=1 -> capture req_addr; go to RD_REQ.
  - Both requests high: write has priority; the refill is still performed after the writeback.
  - Inputs are sampled only in IDLE. Changes on them during a transaction are ignored.
- WB_REQ: m_valid=1, m_we=1, m_addr=captured wb_addr, m_wdata=wb_data. On m_valid&&m_ready -> WB_RESP.
- WB_RESP: wait for m_rvalid (write completion) -> RD_REQ.
- RD_REQ: m_valid=1, m_we=0, m_addr=captured req_addr. On handshake -> RD_RESP.
- RD_RESP: on m_rvalid, register m_rdata into mem_data_out -> ACK.
- ACK: Main_mem_ack=1 for exactly one cycle -> IDLE. mem_data_out holds its value until the next refill.
- Request-channel rules:
  - Once raised, m_valid stays high with stable m_we, m_addr and m_wdata until m_ready is sampled high. No retraction.
  - m_valid is registered and deasserts the cycle after the handshake.
- Responses:
  - m_rvalid outside WB_RESP/RD_RESP is ignored.
  - m_rvalid arriving in the same cycle as the handshake is not accepted; the response must come at least one cycle later.
- Timeout:
  - The counter clears on entry to each RESP state and increments each cycle in that state.
  - On reaching TIMEOUT without m_rvalid: set mem_err and go to IDLE with no ack. The cache's request remains high, so the transaction is retried.
  - Counter width is $clog2(TIMEOUT+1).
- Latency, clean miss, memory with m_ready=1 and rvalid one cycle after acceptance:
  - Request high at edge t0 -> m_valid at t1 -> RD_RESP at t2 (rvalid) -> Main_mem_ack at t3.
  - The cache updates at the end of t3 and hits at t4, so the request is low when IDLE samples it at t4. No spurious second refill.
- Dirty miss: 2 extra cycles minimum, Main_mem_ack at t5.

Decomposition:
- Package cache_mem_bridge_pkg: state enum (bridge_state_t), ADDR_W/DATA_W defaults, word-align helper function.
- Optional sub-module mem_timeout_cnt: parameterised down-counter with clear, enable and expire outputs. Everything else lives in one module.

Test Plan:
1. Clean refill: mem_read_req=1, req_addr=0x0000_0044, memory returns 0xDEADBEEF one cycle after accept -> m_addr=0x44, m_we=0; Main_mem_ack pulses at t3 with mem_data_out=0xDEADBEEF; busy low at t4.
2. Dirty miss: mem_write_req=1, wb_addr=0x0000_1004, wb_data=0xA5A5A5A5, req_addr=0x0000_2004, read data 0x12345678 -> write to 0x1004 with 0xA5A5A5A5 first, then read of 0x2004; ack at t5 with 0x12345678.
3. Backpressure: m_ready held 0 for 4 cycles in RD_REQ -> m_valid and m_addr stable all 4 cycles; single handshake; ack delayed exactly 4 cycles.
4. Simultaneous mem_read_req=1 and mem_write_req=1 -> writeback issued first, then refill; exactly one ack.
5. Timeout: TIMEOUT=8, m_rvalid never asserted in RD_RESP -> after 8 cycles mem_err=1 and back to IDLE with no ack; retry with a normal response acks and mem_err stays 1.
6. Reset in WB_RESP, plus a stray m_rvalid in IDLE -> all outputs return to reset values the next cycle; the stray response is ignored with no ack and no state change.

Source files
------------

// File: rtl/cache_mem_bridge_pkg.sv
// Shared types and helpers for the cache-to-main-memory bridge.
package cache_mem_bridge_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        WB_REQ,
        WB_RESP,
        RD_REQ,
        RD_RESP,
        ACK
    } bridge_state_t;

    // Callers size-cast in and out; memory is word-addressed, so the byte offset is dropped.
    function automatic logic [63:0] word_align(input logic [63:0] addr);
        return {addr[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// Response watchdog: reloads on load, counts down while enabled, and flags
// expiry on the last enabled cycle of a TIMEOUT-cycle window.
module mem_timeout_cnt #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = en && (cnt_q == '0);

endmodule

// File: rtl/cache_mem_bridge.sv
// Runs writeback/refill sequences on a single-outstanding memory channel on
// behalf of the cache, returning the refill word with a one-cycle ack.
//
// state   | meaning
// IDLE    | waiting for a miss request from the cache
// WB_REQ  | victim write presented, waiting for m_ready
// WB_RESP | waiting for write completion (m_rvalid)
// RD_REQ  | refill read presented, waiting for m_ready
// RD_RESP | waiting for read data (m_rvalid)
// ACK     | Main_mem_ack pulse with refill data
module cache_mem_bridge
    import cache_mem_bridge_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read_req,
    input  logic              mem_write_req,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              Main_mem_ack,
    output logic [DATA_W-1:0] mem_data_out,
    output logic              busy,
    output logic              mem_err,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata
);

    bridge_state_t     state_q, state_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              m_valid_q, m_valid_d;
    logic              m_we_q, m_we_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              cnt_load;
    logic              cnt_en;
    logic              cnt_expired;

    mem_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .load    (cnt_load),
        .en      (cnt_en),
        .expired (cnt_expired)
    );

    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        rdata_d    = rdata_q;
        m_valid_d  = m_valid_q;
        m_we_d     = m_we_q;
        ack_d      = 1'b0;
        err_d      = err_q;
        cnt_load   = 1'b0;
        cnt_en     = 1'b0;

        case (state_q)
            IDLE: begin
                // Write wins; the refill address is kept for after the writeback.
                if (mem_write_req) begin
                    req_addr_d = req_addr;
                    m_valid_d  = 1'b1;
                    m_we_d     = 1'b1;
                    m_addr_d   = ADDR_W'(word_align(64'(wb_addr)));
                    m_wdata_d  = wb_data;
                    state_d    = WB_REQ;
                end else if (mem_read_req) begin
                    req_addr_d = req_addr;
                    m_valid_d  = 1'b1;
                    m_we_d     = 1'b0;
                    m_addr_d   = ADDR_W'(word_align(64'(req_addr)));
                    state_d    = RD_REQ;
                end
            end
            WB_REQ: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    cnt_load  = 1'b1;
                    state_d   = WB_RESP;
                end
            end
            WB_RESP: begin
                cnt_en = 1'b1;
                if (m_rvalid) begin
                    m_valid_d = 1'b1;
                    m_we_d    = 1'b0;
                    m_addr_d  = ADDR_W'(word_align(64'(req_addr_q)));
                    state_d   = RD_REQ;
                end else if (cnt_expired) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            RD_REQ: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    cnt_load  = 1'b1;
                    state_d   = RD_RESP;
                end
            end
            RD_RESP: begin
                cnt_en = 1'b1;
                if (m_rvalid) begin
                    rdata_d = m_rdata;
                    ack_d   = 1'b1;
                    state_d = ACK;
                end else if (cnt_expired) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            req_addr_q <= '0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            rdata_q    <= '0;
            m_valid_q  <= 1'b0;
            m_we_q     <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            rdata_q    <= rdata_d;
            m_valid_q  <= m_valid_d;
            m_we_q     <= m_we_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign Main_mem_ack = ack_q;
    assign mem_data_out = rdata_q;
    assign mem_err      = err_q;
    assign m_valid      = m_valid_q;
    assign m_we         = m_we_q;
    assign m_addr       = m_addr_q;
    assign m_wdata      = m_wdata_q;

endmodule

// File: tb/tb_cache_mem_bridge.sv
// Directed bench for cache_mem_bridge: refill, writeback+refill, backpressure,
// request priority, response timeout and reset/stray-response handling.
module tb_cache_mem_bridge;

    logic        clk;
    logic        reset;
    logic        mem_read_req;
    logic        mem_write_req;
    logic [31:0] req_addr;
    logic [31:0] wb_addr;
    logic [31:0] wb_data;
    logic        Main_mem_ack;
    logic [31:0] mem_data_out;
    logic        busy;
    logic        mem_err;
    logic        m_valid;
    logic        m_ready;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_rvalid;
    logic [31:0] m_rdata;

    int n_pass  = 0;
    int n_total = 0;
    int ack_cnt = 0;
    int ack_base;

    cache_mem_bridge #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_read_req  (mem_read_req),
        .mem_write_req (mem_write_req),
        .req_addr      (req_addr),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .Main_mem_ack  (Main_mem_ack),
        .mem_data_out  (mem_data_out),
        .busy          (busy),
        .mem_err       (mem_err),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_we          (m_we),
        .m_addr        (m_addr),
        .m_wdata       (m_wdata),
        .m_rvalid      (m_rvalid),
        .m_rdata       (m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (Main_mem_ack === 1'b1) ack_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        reset = 1'b1; mem_read_req = 1'b0; mem_write_req = 1'b0;
        req_addr = '0; wb_addr = '0; wb_data = '0;
        m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
        tick(); tick();
        reset = 1'b0;
        tick();
        check("rst_busy", busy, 0);
        check("rst_ack", Main_mem_ack, 0);
        check("rst_mvalid", m_valid, 0);
        check("rst_mwe", m_we, 0);
        check("rst_maddr", m_addr, 0);
        check("rst_mwdata", m_wdata, 0);
        check("rst_data", mem_data_out, 0);
        check("rst_err", mem_err, 0);

        // 1: clean refill
        mem_read_req = 1'b1; req_addr = 32'h0000_0044; m_ready = 1'b1;
        tick(); // t1
        check("t1_mvalid", m_valid, 1);
        check("t1_mwe", m_we, 0);
        check("t1_maddr", m_addr, 32'h44);
        check("t1_busy", busy, 1);
        tick(); // t2
        check("t1_t2_mvalid_drop", m_valid, 0);
        check("t1_t2_ack", Main_mem_ack, 0);
        m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF;
        tick(); // t3
        m_rvalid = 1'b0;
        check("t1_t3_ack", Main_mem_ack, 1);
        check("t1_t3_data", mem_data_out, 32'hDEAD_BEEF);
        tick(); // t4
        mem_read_req = 1'b0;
        check("t1_t4_ack", Main_mem_ack, 0);
        check("t1_t4_busy", busy, 0);
        check("t1_t4_data_hold", mem_data_out, 32'hDEAD_BEEF);
        tick();
        check("t1_t5_busy", busy, 0);
        check("t1_ackcnt", ack_cnt, 1);

        // 2: dirty miss
        mem_write_req = 1'b1; wb_addr = 32'h0000_1004; wb_data = 32'hA5A5_A5A5;
        req_addr = 32'h0000_2004;
        tick(); // t1
        check("t2_wr_mvalid", m_valid, 1);
        check("t2_wr_mwe", m_we, 1);
        check("t2_wr_maddr", m_addr, 32'h1004);
        check("t2_wr_mwdata", m_wdata, 32'hA5A5_A5A5);
        tick(); // t2
        check("t2_wbresp_mvalid", m_valid, 0);
        m_rvalid = 1'b1;
        tick(); // t3
        m_rvalid = 1'b0;
        check("t2_rd_mvalid", m_valid, 1);
        check("t2_rd_mwe", m_we, 0);
        check("t2_rd_maddr", m_addr, 32'h2004);
        tick(); // t4
        check("t2_t4_ack", Main_mem_ack, 0);
        m_rvalid = 1'b1; m_rdata = 32'h1234_5678;
        tick(); // t5
        m_rvalid = 1'b0;
        check("t2_t5_ack", Main_mem_ack, 1);
        check("t2_t5_data", mem_data_out, 32'h1234_5678);
        tick();
        mem_write_req = 1'b0;
        check("t2_t6_busy", busy, 0);
        check("t2_ackcnt", ack_cnt, 2);

        // 3: backpressure on the read request, unaligned address, input changes ignored
        mem_read_req = 1'b1; req_addr = 32'h0000_0047; m_ready = 1'b0;
        tick(); // t1
        check("t3_c1_mvalid", m_valid, 1);
        check("t3_c1_maddr", m_addr, 32'h44);
        req_addr = 32'h0000_0999;
        for (int i = 2; i <= 4; i++) begin
            tick();
            check($sformatf("t3_c%0d_mvalid", i), m_valid, 1);
            check($sformatf("t3_c%0d_maddr", i), m_addr, 32'h44);
            check($sformatf("t3_c%0d_mwe", i), m_we, 0);
        end
        tick(); // t5
        m_ready = 1'b1;
        check("t3_t5_mvalid", m_valid, 1);
        check("t3_t5_maddr", m_addr, 32'h44);
        tick(); // t6
        check("t3_t6_mvalid", m_valid, 0);
        check("t3_t6_ack", Main_mem_ack, 0);
        m_rvalid = 1'b1; m_rdata = 32'hCAFE_F00D;
        tick(); // t7
        m_rvalid = 1'b0;
        check("t3_t7_ack", Main_mem_ack, 1);
        check("t3_t7_data", mem_data_out, 32'hCAFE_F00D);
        check("t3_t7_mvalid", m_valid, 0);
        tick();
        mem_read_req = 1'b0;
        check("t3_t8_busy", busy, 0);
        check("t3_ackcnt", ack_cnt, 3);

        // 4: both requests together
        ack_base = ack_cnt;
        mem_read_req = 1'b1; mem_write_req = 1'b1;
        wb_addr = 32'h0000_0300; wb_data = 32'h1111_2222; req_addr = 32'h0000_0400;
        tick(); // t1
        check("t4_wr_mwe", m_we, 1);
        check("t4_wr_maddr", m_addr, 32'h300);
        check("t4_wr_mwdata", m_wdata, 32'h1111_2222);
        tick(); // t2
        m_rvalid = 1'b1;
        tick(); // t3
        m_rvalid = 1'b0;
        check("t4_rd_mvalid", m_valid, 1);
        check("t4_rd_mwe", m_we, 0);
        check("t4_rd_maddr", m_addr, 32'h400);
        tick(); // t4
        m_rvalid = 1'b1; m_rdata = 32'h0BAD_F00D;
        tick(); // t5
        m_rvalid = 1'b0;
        check("t4_t5_ack", Main_mem_ack, 1);
        check("t4_t5_data", mem_data_out, 32'h0BAD_F00D);
        tick();
        mem_read_req = 1'b0; mem_write_req = 1'b0;
        tick();
        check("t4_busy", busy, 0);
        check("t4_one_ack", ack_cnt - ack_base, 1);

        // 5: timeout in RD_RESP (TIMEOUT=8), then retry with a real response
        ack_base = ack_cnt;
        mem_read_req = 1'b1; req_addr = 32'h0000_0080;
        tick(); // t1
        check("t5_maddr", m_addr, 32'h80);
        tick(); // t2: first RD_RESP cycle
        for (int i = 3; i <= 9; i++) begin
            tick();
        end
        check("t5_t9_busy", busy, 1);
        check("t5_t9_err", mem_err, 0);
        tick(); // t10
        check("t5_t10_busy", busy, 0);
        check("t5_t10_err", mem_err, 1);
        check("t5_noack", ack_cnt - ack_base, 0);
        tick(); // t11: retry
        check("t5_retry_mvalid", m_valid, 1);
        check("t5_retry_maddr", m_addr, 32'h80);
        tick(); // t12
        m_rvalid = 1'b1; m_rdata = 32'h5555_AAAA;
        tick(); // t13
        m_rvalid = 1'b0;
        check("t5_retry_ack", Main_mem_ack, 1);
        check("t5_retry_data", mem_data_out, 32'h5555_AAAA);
        check("t5_err_sticky", mem_err, 1);
        tick();
        mem_read_req = 1'b0;
        tick();
        check("t5_err_sticky2", mem_err, 1);

        // 6: reset in WB_RESP with in-flight response, then stray response in IDLE
        ack_base = ack_cnt;
        mem_write_req = 1'b1; wb_addr = 32'h0000_0500; wb_data = 32'h0000_0077;
        req_addr = 32'h0000_0600;
        tick(); // t1
        tick(); // t2: WB_RESP
        check("t6_wbresp_busy", busy, 1);
        reset = 1'b1; m_rvalid = 1'b1; m_rdata = 32'hFFFF_0000;
        tick(); // t3
        reset = 1'b0; mem_write_req = 1'b0;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_mvalid", m_valid, 0);
        check("t6_rst_mwe", m_we, 0);
        check("t6_rst_maddr", m_addr, 0);
        check("t6_rst_mwdata", m_wdata, 0);
        check("t6_rst_data", mem_data_out, 0);
        check("t6_rst_err", mem_err, 0);
        check("t6_rst_ack", Main_mem_ack, 0);
        tick();
        check("t6_stray_busy", busy, 0);
        check("t6_stray_ack", Main_mem_ack, 0);
        tick();
        m_rvalid = 1'b0;
        check("t6_stray_busy2", busy, 0);
        check("t6_stray_data", mem_data_out, 0);
        check("t6_stray_mvalid", m_valid, 0);
        check("t6_noack", ack_cnt - ack_base, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
